// File: rtl/ixc_readback_if.sv
// Host readback channel of ixc_readback: capture request, probed vector and the chunked valid/ready stream.
// Port P exists only when IXC_READBACK_PARITY_EN is defined.
interface ixc_readback_if #(
  parameter int WIDTH = 106,
  parameter int CHUNK = 32
);
  logic             REQ;
  logic [WIDTH-1:0] R;
  logic             BUSY;
  logic [CHUNK-1:0] D;
  logic             V;
  logic             RDY;
  logic             LAST;
  logic             DROP;
`ifdef IXC_READBACK_PARITY_EN
  logic             P;

  modport master (
    input  REQ, R, RDY,
    output BUSY, D, V, LAST, DROP, P
  );

  modport slave (
    output REQ, R, RDY,
    input  BUSY, D, V, LAST, DROP, P
  );
`else
  modport master (
    input  REQ, R, RDY,
    output BUSY, D, V, LAST, DROP
  );

  modport slave (
    output REQ, R, RDY,
    input  BUSY, D, V, LAST, DROP
  );
`endif
endinterface

// File: rtl/ixc_readback.sv
// Snapshots a WIDTH-bit design vector on REQ and streams it out as CHUNK-bit words, lowest first.
// Optional even-parity output P is enabled by defining IXC_READBACK_PARITY_EN.
module ixc_readback #(
  parameter int WIDTH = 106,
  parameter int CHUNK = 32
) (
  input  logic          CLK,
  input  logic          RST,
  ixc_readback_if.master bus
);

  localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int PADW   = NCHUNK * CHUNK;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t           state;
  logic [PADW-1:0]  shadow;
  logic [IDXW-1:0]  idx;
  logic [IDXW-1:0]  idx_nxt;
  logic [CHUNK-1:0] d;
  logic             v;
  logic             busy;
  logic             last;
  logic             drop;

  // The shadow is zero-extended to a whole number of chunks, so the top word is padded with zeros.
  function automatic logic [CHUNK-1:0] chunk_at(input logic [PADW-1:0] s,
                                                input logic [IDXW-1:0] i);
    return s[i*CHUNK +: CHUNK];
  endfunction

  assign idx_nxt = idx + 1'b1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      shadow <= '0;
      idx    <= '0;
      d      <= '0;
      v      <= 1'b0;
      busy   <= 1'b0;
      last   <= 1'b0;
      drop   <= 1'b0;
    end else begin
      drop <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.REQ) begin
            shadow <= PADW'(bus.R);
            idx    <= '0;
            d      <= chunk_at(PADW'(bus.R), '0);
            v      <= 1'b1;
            busy   <= 1'b1;
            last   <= (NCHUNK == 1);
            state  <= SEND;
          end
        end
        SEND: begin
          // A request while a snapshot is outstanding, including on the final transfer, is refused.
          drop <= bus.REQ;
          if (bus.RDY) begin
            if (idx == LAST_IDX) begin
              state <= IDLE;
              idx   <= '0;
              d     <= '0;
              v     <= 1'b0;
              busy  <= 1'b0;
              last  <= 1'b0;
            end else begin
              idx  <= idx_nxt;
              d    <= chunk_at(shadow, idx_nxt);
              last <= (idx_nxt == LAST_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.D    = d;
  assign bus.V    = v;
  assign bus.BUSY = busy;
  assign bus.LAST = last;
  assign bus.DROP = drop;

`ifdef IXC_READBACK_PARITY_EN
  // D is forced to zero whenever V is low, so P is also zero then.
  assign bus.P = ^d;
`endif

endmodule

// File: tb/tb_ixc_readback.sv
// Randomized self-checking bench for ixc_readback against a queue-based transaction model.
// Parity checks are compiled in when IXC_READBACK_PARITY_EN is defined.
module tb_ixc_readback;

  localparam int W  = 106;
  localparam int C  = 32;
  localparam int NC = (W + C - 1) / C;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  ixc_readback_if #(.WIDTH(W), .CHUNK(C)) bus ();

  ixc_readback #(.WIDTH(W), .CHUNK(C)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: queue of words still owed to the host; empty queue means idle.
  logic [C-1:0] mq[$];
  logic         m_drop;

  function automatic logic [C-1:0] word_of(input logic [W-1:0] r, input int i);
    return C'(r >> (i * C));
  endfunction

  function automatic logic [W-1:0] rand_r();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    return W'(t);
  endfunction

  function automatic logic ev();
    return mq.size() != 0;
  endfunction

  function automatic logic [C-1:0] ed();
    return (mq.size() != 0) ? mq[0] : '0;
  endfunction

  function automatic logic el();
    return mq.size() == 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_drop = 1'b0;
    end else if (mq.size() == 0) begin
      m_drop = 1'b0;
      if (bus.REQ)
        for (int i = 0; i < NC; i++) mq.push_back(word_of(bus.R, i));
    end else begin
      m_drop = bus.REQ;
      if (bus.RDY) void'(mq.pop_front());
    end
    #1;
  endtask

  task automatic restart();
    rst = 1'b1; bus.REQ = 1'b0; bus.RDY = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    restart();
    rst = 1'b1;
    bus.R = rand_r();
    bus.REQ = 1'b1;
    tick();
    total += 5;
    if (bus.V !== 1'b0)    begin bad++; $display("FAIL reset_v got=%b exp=0", bus.V); end
    if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.BUSY); end
    if (bus.LAST !== 1'b0) begin bad++; $display("FAIL reset_last got=%b exp=0", bus.LAST); end
    if (bus.DROP !== 1'b0) begin bad++; $display("FAIL reset_drop got=%b exp=0", bus.DROP); end
    if (bus.D !== '0)      begin bad++; $display("FAIL reset_d got=%h exp=0", bus.D); end
`ifdef IXC_READBACK_PARITY_EN
    total++;
    if (bus.P !== 1'b0)    begin bad++; $display("FAIL reset_p got=%b exp=0", bus.P); end
`endif
    rst = 1'b0;
    bus.REQ = 1'b0;
  endtask

  task automatic test_basic();
    // The literal has 25 hex digits, so bits [105:96] hold just 2.
    logic [C-1:0] exp_w [4] = '{32'h1, 32'h2, 32'h3, 32'h2};
    restart();
    bus.R = 106'h2_0000_0003_0000_0002_0000_0001;
    bus.REQ = 1'b1; bus.RDY = 1'b1;
    tick();
    bus.REQ = 1'b0;
    bus.R = rand_r();
    for (int k = 0; k < 4; k++) begin
      total += 4;
      if (bus.V !== 1'b1) begin bad++; $display("FAIL basic_v k=%0d got=%b exp=1", k, bus.V); end
      if (bus.BUSY !== 1'b1) begin bad++; $display("FAIL basic_busy k=%0d got=%b exp=1", k, bus.BUSY); end
      if (bus.D !== exp_w[k] || bus.D !== ed())
        begin bad++; $display("FAIL basic_d k=%0d got=%h exp=%h", k, bus.D, exp_w[k]); end
      if (bus.LAST !== (k == 3)) begin bad++; $display("FAIL basic_last k=%0d got=%b exp=%b", k, bus.LAST, k == 3); end
      tick();
    end
    total += 2;
    if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL basic_busy_end got=%b exp=0", bus.BUSY); end
    if (bus.V !== 1'b0)    begin bad++; $display("FAIL basic_v_end got=%b exp=0", bus.V); end
  endtask

  task automatic test_rdy_stall();
    logic         pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [C-1:0] exp_w [4] = '{32'h1, 32'h2, 32'h3, 32'h2};
    logic [C-1:0] prev_d;
    logic         prev_last;
    int           xfers;
    restart();
    bus.R = 106'h2_0000_0003_0000_0002_0000_0001;
    bus.REQ = 1'b1; bus.RDY = 1'b0;
    tick();
    bus.REQ = 1'b0;
    xfers = 0;
    prev_d = bus.D; prev_last = bus.LAST;
    for (int k = 0; k < 7; k++) begin
      bus.RDY = pat[k];
      total += 2;
      if (bus.D !== ed()) begin bad++; $display("FAIL stall_d k=%0d got=%h exp=%h", k, bus.D, ed()); end
      if (bus.LAST !== el()) begin bad++; $display("FAIL stall_last k=%0d got=%b exp=%b", k, bus.LAST, el()); end
      if (k > 0 && !pat[k-1]) begin
        total++;
        if (bus.D !== prev_d || bus.LAST !== prev_last)
          begin bad++; $display("FAIL stall_hold k=%0d got=%h/%b exp=%h/%b", k, bus.D, bus.LAST, prev_d, prev_last); end
      end
      if (bus.V && bus.RDY) begin
        if (xfers < 4) begin
          total++;
          if (bus.D !== exp_w[xfers]) begin bad++; $display("FAIL stall_order n=%0d got=%h exp=%h", xfers, bus.D, exp_w[xfers]); end
        end
        xfers++;
      end
      prev_d = bus.D; prev_last = bus.LAST;
      tick();
    end
    total += 2;
    if (xfers !== 4) begin bad++; $display("FAIL stall_count got=%0d exp=4", xfers); end
    if (bus.V !== 1'b0) begin bad++; $display("FAIL stall_v_end got=%b exp=0", bus.V); end
  endtask

  task automatic test_snapshot();
    logic [C-1:0] exp_w [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_03FF};
    restart();
    bus.R = '1;
    bus.REQ = 1'b1; bus.RDY = 1'b1;
    tick();
    bus.REQ = 1'b0;
    bus.R = '0;
    for (int k = 0; k < 4; k++) begin
      total += 2;
      if (bus.V !== 1'b1) begin bad++; $display("FAIL snap_v k=%0d got=%b exp=1", k, bus.V); end
      if (bus.D !== exp_w[k]) begin bad++; $display("FAIL snap_d k=%0d got=%h exp=%h", k, bus.D, exp_w[k]); end
      tick();
    end
  endtask

  task automatic test_req_held();
    int drops;
    restart();
    bus.REQ = 1'b1; bus.RDY = 1'b1;
    drops = 0;
    for (int k = 0; k < 14; k++) begin
      bus.R = rand_r();
      tick();
      if (k < 6 && bus.DROP === 1'b1) drops++;
      total += 3;
      if (bus.V !== ev()) begin bad++; $display("FAIL held_v k=%0d got=%b exp=%b", k, bus.V, ev()); end
      if (bus.DROP !== m_drop) begin bad++; $display("FAIL held_drop k=%0d got=%b exp=%b", k, bus.DROP, m_drop); end
      if (ev() && (bus.D !== ed() || bus.LAST !== el()))
        begin bad++; $display("FAIL held_data k=%0d got=%h/%b exp=%h/%b", k, bus.D, bus.LAST, ed(), el()); end
    end
    total++;
    if (drops !== 4) begin bad++; $display("FAIL held_drop_count got=%0d exp=4", drops); end
    bus.REQ = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] r2;
    restart();
    bus.R = rand_r();
    bus.REQ = 1'b1; bus.RDY = 1'b1;
    tick();
    bus.REQ = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    total += 4;
    if (bus.V !== 1'b0)    begin bad++; $display("FAIL mid_v got=%b exp=0", bus.V); end
    if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", bus.BUSY); end
    if (bus.LAST !== 1'b0) begin bad++; $display("FAIL mid_last got=%b exp=0", bus.LAST); end
    if (bus.D !== '0)      begin bad++; $display("FAIL mid_d got=%h exp=0", bus.D); end
    rst = 1'b0;
    r2 = rand_r();
    bus.R = r2; bus.REQ = 1'b1;
    tick();
    bus.REQ = 1'b0;
    total += 2;
    if (bus.V !== 1'b1 || bus.LAST !== 1'b0) begin bad++; $display("FAIL mid_restart_vl got=%b/%b exp=1/0", bus.V, bus.LAST); end
    if (bus.D !== r2[C-1:0]) begin bad++; $display("FAIL mid_restart_d got=%h exp=%h", bus.D, r2[C-1:0]); end
  endtask

  task automatic test_random();
    restart();
    for (int k = 0; k < 400; k++) begin
      rst     = ($urandom_range(99) < 2);
      bus.REQ = ($urandom_range(99) < 30);
      bus.RDY = ($urandom_range(99) < 60);
      bus.R   = ($urandom_range(9) == 0) ? '1 : rand_r();
      tick();
      total += 4;
      if (bus.V !== ev())      begin bad++; $display("FAIL rand_v k=%0d got=%b exp=%b", k, bus.V, ev()); end
      if (bus.BUSY !== ev())   begin bad++; $display("FAIL rand_busy k=%0d got=%b exp=%b", k, bus.BUSY, ev()); end
      if (bus.DROP !== m_drop) begin bad++; $display("FAIL rand_drop k=%0d got=%b exp=%b", k, bus.DROP, m_drop); end
      if (ev() && (bus.D !== ed() || bus.LAST !== el()))
        begin bad++; $display("FAIL rand_data k=%0d got=%h/%b exp=%h/%b", k, bus.D, bus.LAST, ed(), el()); end
`ifdef IXC_READBACK_PARITY_EN
      total++;
      if (bus.P !== (ev() ? ^ed() : 1'b0)) begin bad++; $display("FAIL rand_p k=%0d got=%b exp=%b", k, bus.P, ev() ? ^ed() : 1'b0); end
`endif
    end
    rst = 1'b0;
  endtask

`ifdef IXC_READBACK_PARITY_EN
  task automatic test_parity();
    logic exp_p [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    restart();
    bus.R = 106'h7;
    bus.REQ = 1'b1; bus.RDY = 1'b1;
    tick();
    bus.REQ = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (bus.P !== exp_p[k]) begin bad++; $display("FAIL parity k=%0d got=%b exp=%b", k, bus.P, exp_p[k]); end
      tick();
    end
    total++;
    if (bus.P !== 1'b0) begin bad++; $display("FAIL parity_idle got=%b exp=0", bus.P); end
  endtask
`endif

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    bus.REQ = 1'b0;
    bus.RDY = 1'b0;
    bus.R = '0;
    m_drop = 1'b0;
    test_reset();
    test_basic();
    test_rdy_stall();
    test_snapshot();
    test_req_held();
    test_reset_mid();
`ifdef IXC_READBACK_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
